// File: rtl/vx_barrier_unit_pkg.sv
// Shared types and constants for the warp barrier unit.
// The optional PERF_BARRIER_EN build adds stall/release counters to the top.
`ifndef VX_BARRIER_UNIT_PKG_SV
`define VX_BARRIER_UNIT_PKG_SV

`define GPU_BARRIER_REQ_BITS(nwBits, nbBits) ((2 * (nwBits)) + (nbBits))

package vx_barrier_unit_pkg;

   localparam int BAR_NUM_WARPS    = 4;
   localparam int BAR_NUM_BARRIERS = 4;
   localparam int BAR_NW_BITS      = $clog2(BAR_NUM_WARPS);
   localparam int BAR_NB_BITS      = (BAR_NUM_BARRIERS > 1) ? $clog2(BAR_NUM_BARRIERS) : 1;

   typedef enum logic [1:0] {
      BAR_ERR_NONE = 2'd0,
      BAR_ERR_DUP  = 2'd1,
      BAR_ERR_SIZE = 2'd2
   } bar_err_e;

   typedef enum logic {
      SLOT_IDLE    = 1'b0,
      SLOT_FILLING = 1'b1
   } slot_state_e;

   typedef struct packed {
      logic [BAR_NW_BITS-1:0] wid;
      logic [BAR_NB_BITS-1:0] id;
      logic [BAR_NW_BITS-1:0] size_m1;
   } gpu_barrier_req_t;

   typedef struct packed {
      logic [BAR_NUM_WARPS-1:0] wmask;
   } gpu_barrier_rel_t;

   function automatic logic [63:0] popCount(input logic [63:0] value);
      logic [63:0] total;
      total = '0;
      for (int i = 0; i < 64; i++) begin
         total = total + {63'd0, value[i]};
      end
      return total;
   endfunction

endpackage

`endif

// File: rtl/vx_barrier_unit_entry.sv
// One barrier slot: arrival mask, arrival count, latched size, and the
// decision to release, reject a duplicate, or flag a size mismatch.
module vx_barrier_unit_entry
   import vx_barrier_unit_pkg::*;
#(
   parameter int NUM_WARPS = 4,
   parameter int NW_BITS   = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 hit_i,
   input  logic [NW_BITS-1:0]   wid_i,
   input  logic [NW_BITS-1:0]   sizeM1_i,
   output logic [NUM_WARPS-1:0] wmask_o,
   output logic                 fire_o,
   output logic [NUM_WARPS-1:0] fireMask_o,
   output logic [1:0]           err_o
);

   slot_state_e          state_q, state_d;
   logic [NUM_WARPS-1:0] wmask_q, wmask_d;
   logic [NW_BITS-1:0]   count_q, count_d;
   logic [NW_BITS-1:0]   sizeM1_q, sizeM1_d;
   logic [NUM_WARPS-1:0] widHot;
   logic [NW_BITS-1:0]   countInc;

   assign widHot   = NUM_WARPS'(1) << wid_i;
   assign countInc = count_q + NW_BITS'(1);
   assign wmask_o  = wmask_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= SLOT_IDLE;
         wmask_q  <= '0;
         count_q  <= '0;
         sizeM1_q <= '0;
      end else begin
         state_q  <= state_d;
         wmask_q  <= wmask_d;
         count_q  <= count_d;
         sizeM1_q <= sizeM1_d;
      end
   end

   // A single-warp barrier never parks; a duplicate arrival leaves the slot untouched.
   always_comb begin
      state_d    = state_q;
      wmask_d    = wmask_q;
      count_d    = count_q;
      sizeM1_d   = sizeM1_q;
      fire_o     = 1'b0;
      fireMask_o = '0;
      err_o      = BAR_ERR_NONE;
      if (hit_i) begin
         case (state_q)
            SLOT_IDLE: begin
               if (sizeM1_i == '0) begin
                  fire_o     = 1'b1;
                  fireMask_o = widHot;
               end else begin
                  state_d  = SLOT_FILLING;
                  wmask_d  = widHot;
                  count_d  = '0;
                  sizeM1_d = sizeM1_i;
               end
            end
            SLOT_FILLING: begin
               if (|(wmask_q & widHot)) begin
                  err_o = BAR_ERR_DUP;
               end else begin
                  if (sizeM1_i != sizeM1_q) begin
                     err_o = BAR_ERR_SIZE;
                  end
                  if (countInc == sizeM1_q) begin
                     fire_o     = 1'b1;
                     fireMask_o = wmask_q | widHot;
                     state_d    = SLOT_IDLE;
                     wmask_d    = '0;
                     count_d    = '0;
                  end else begin
                     wmask_d = wmask_q | widHot;
                     count_d = countInc;
                  end
               end
            end
            default: state_d = SLOT_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/vx_barrier_unit.sv
// Table of barrier slots with a single flow-controlled release register.
// Define PERF_BARRIER_EN to add the stall-cycle and release counters.
module vx_barrier_unit
   import vx_barrier_unit_pkg::*;
#(
   parameter int NUM_WARPS    = 4,
   parameter int NUM_BARRIERS = 4,
   parameter int NW_BITS      = $clog2(NUM_WARPS),
   parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [NW_BITS-1:0]   req_wid,
   input  logic [NB_BITS-1:0]   req_id,
   input  logic [NW_BITS-1:0]   req_size_m1,
   output logic                 release_valid,
   input  logic                 release_ready,
   output logic [NUM_WARPS-1:0] release_wmask,
   output logic [NUM_WARPS-1:0] stalled_wmask,
   output logic                 err_valid,
   output logic [1:0]           err_code
`ifdef PERF_BARRIER_EN
   ,
   output logic [63:0]          perf_stall_cycles,
   output logic [31:0]          perf_releases
`endif
);

   logic                 accept;
   logic                 slotHit      [NUM_BARRIERS];
   logic [NUM_WARPS-1:0] slotWmask    [NUM_BARRIERS];
   logic                 slotFire     [NUM_BARRIERS];
   logic [NUM_WARPS-1:0] slotFireMask [NUM_BARRIERS];
   logic [1:0]           slotErr      [NUM_BARRIERS];

   logic                 fireAny;
   logic [NUM_WARPS-1:0] fireMask;
   logic [1:0]           errAny;

   logic                 relValid_q;
   logic [NUM_WARPS-1:0] relWmask_q;
   logic                 errValid_q;
   logic [1:0]           errCode_q;

   // The release register only reloads when it is empty or draining, so a completion is never dropped.
   assign req_ready = reset_n && (!relValid_q || release_ready);
   assign accept    = req_valid && req_ready;

   for (genvar i = 0; i < NUM_BARRIERS; i++) begin : gSlot
      assign slotHit[i] = accept && (req_id == NB_BITS'(i));

      vx_barrier_unit_entry #(
         .NUM_WARPS (NUM_WARPS),
         .NW_BITS   (NW_BITS)
      ) uEntry (
         .clk        (clk),
         .reset_n    (reset_n),
         .hit_i      (slotHit[i]),
         .wid_i      (req_wid),
         .sizeM1_i   (req_size_m1),
         .wmask_o    (slotWmask[i]),
         .fire_o     (slotFire[i]),
         .fireMask_o (slotFireMask[i]),
         .err_o      (slotErr[i])
      );
   end

   // At most one slot is hit per cycle, so OR-ing the slot results is a plain select.
   always_comb begin
      fireAny       = 1'b0;
      fireMask      = '0;
      errAny        = BAR_ERR_NONE;
      stalled_wmask = '0;
      for (int i = 0; i < NUM_BARRIERS; i++) begin
         fireAny       = fireAny | slotFire[i];
         fireMask      = fireMask | slotFireMask[i];
         errAny        = errAny | slotErr[i];
         stalled_wmask = stalled_wmask | slotWmask[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         relValid_q <= 1'b0;
         relWmask_q <= '0;
         errValid_q <= 1'b0;
         errCode_q  <= BAR_ERR_NONE;
      end else begin
         if (fireAny) begin
            relValid_q <= 1'b1;
            relWmask_q <= fireMask;
         end else if (release_ready) begin
            relValid_q <= 1'b0;
            relWmask_q <= '0;
         end
         errValid_q <= (errAny != BAR_ERR_NONE);
         errCode_q  <= errAny;
      end
   end

   assign release_valid = relValid_q;
   assign release_wmask = relWmask_q;
   assign err_valid     = errValid_q;
   assign err_code      = errCode_q;

`ifdef PERF_BARRIER_EN
   logic [63:0] perfStall_q;
   logic [31:0] perfRel_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perfStall_q <= '0;
         perfRel_q   <= '0;
      end else begin
         perfStall_q <= perfStall_q + popCount(64'(stalled_wmask));
         if (relValid_q && release_ready) begin
            perfRel_q <= perfRel_q + 32'd1;
         end
      end
   end

   assign perf_stall_cycles = perfStall_q;
   assign perf_releases     = perfRel_q;
`endif

endmodule

// File: tb/tb_vx_barrier_unit.sv
// Directed bench for vx_barrier_unit with hand-computed expectations.
// Compile with PERF_BARRIER_EN defined to also exercise the perf counters.
module tb_vx_barrier_unit;

   logic       clk;
   logic       reset_n;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_wid;
   logic [1:0] req_id;
   logic [1:0] req_size_m1;
   logic       release_valid;
   logic       release_ready;
   logic [3:0] release_wmask;
   logic [3:0] stalled_wmask;
   logic       err_valid;
   logic [1:0] err_code;
`ifdef PERF_BARRIER_EN
   logic [63:0] perf_stall_cycles;
   logic [31:0] perf_releases;
   logic [63:0] stallSnap;
   logic [31:0] relSnap;
`endif

   int totalCount = 0;
   int badCount   = 0;

   vx_barrier_unit #(
      .NUM_WARPS    (4),
      .NUM_BARRIERS (4)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_wid       (req_wid),
      .req_id        (req_id),
      .req_size_m1   (req_size_m1),
      .release_valid (release_valid),
      .release_ready (release_ready),
      .release_wmask (release_wmask),
      .stalled_wmask (stalled_wmask),
      .err_valid     (err_valid),
      .err_code      (err_code)
`ifdef PERF_BARRIER_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_releases     (perf_releases)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
      end
   endtask

   // Present one request for a single edge, then sample #1 after that edge.
   task automatic applyStimulus(input logic valid, input logic [1:0] wid, input logic [1:0] id,
                                input logic [1:0] sizeM1);
      req_valid   = valid;
      req_wid     = wid;
      req_id      = id;
      req_size_m1 = sizeM1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 2'd0, 2'd0, 2'd0);
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
   endtask

   initial begin
      reset_n       = 1'b0;
      req_valid     = 1'b0;
      req_wid       = '0;
      req_id        = '0;
      req_size_m1   = '0;
      release_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_rel_valid", release_valid, 0);
      checkOutput("rst_rel_wmask", release_wmask, 0);
      checkOutput("rst_stalled", stalled_wmask, 0);
      checkOutput("rst_err_valid", err_valid, 0);
      checkOutput("rst_err_code", err_code, 0);
      reset_n = 1'b1;
      #1;
      checkOutput("post_rst_req_ready", req_ready, 1);

      // Size-4 barrier 1, warps 0..3 in order.
      applyStimulus(1'b1, 2'd0, 2'd1, 2'd3);
      checkOutput("b1_w0_stalled", stalled_wmask, 4'b0001);
      checkOutput("b1_w0_rel_valid", release_valid, 0);
      applyStimulus(1'b1, 2'd1, 2'd1, 2'd3);
      checkOutput("b1_w1_stalled", stalled_wmask, 4'b0011);
      applyStimulus(1'b1, 2'd2, 2'd1, 2'd3);
      checkOutput("b1_w2_stalled", stalled_wmask, 4'b0111);
      checkOutput("b1_w2_rel_valid", release_valid, 0);
      applyStimulus(1'b1, 2'd3, 2'd1, 2'd3);
      checkOutput("b1_w3_rel_valid", release_valid, 1);
      checkOutput("b1_w3_rel_wmask", release_wmask, 4'b1111);
      checkOutput("b1_w3_stalled", stalled_wmask, 4'b0000);
      checkOutput("b1_w3_err_valid", err_valid, 0);
      idleCycle();
      checkOutput("b1_drained", release_valid, 0);

      // Single-warp barrier releases immediately.
      applyStimulus(1'b1, 2'd2, 2'd2, 2'd0);
      checkOutput("solo_rel_valid", release_valid, 1);
      checkOutput("solo_rel_wmask", release_wmask, 4'b0100);
      checkOutput("solo_stalled", stalled_wmask, 4'b0000);

      // Back-to-back single-warp releases: accept and reload in the same cycle.
      applyStimulus(1'b1, 2'd3, 2'd2, 2'd0);
      checkOutput("reload_rel_valid", release_valid, 1);
      checkOutput("reload_rel_wmask", release_wmask, 4'b1000);
      idleCycle();
      checkOutput("reload_drained", release_valid, 0);

      // Duplicate arrival on barrier 0.
      applyStimulus(1'b1, 2'd1, 2'd0, 2'd1);
      checkOutput("dup_first_stalled", stalled_wmask, 4'b0010);
      checkOutput("dup_first_err_valid", err_valid, 0);
      applyStimulus(1'b1, 2'd1, 2'd0, 2'd1);
      checkOutput("dup_err_valid", err_valid, 1);
      checkOutput("dup_err_code", err_code, 1);
      checkOutput("dup_stalled", stalled_wmask, 4'b0010);
      checkOutput("dup_rel_valid", release_valid, 0);
      idleCycle();
      checkOutput("dup_err_cleared", err_valid, 0);
      checkOutput("dup_code_cleared", err_code, 0);

      // Complete barrier 0 under back-pressure for 3 cycles.
      release_ready = 1'b0;
      applyStimulus(1'b1, 2'd3, 2'd0, 2'd1);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("bp_req_ready_%0d", i), req_ready, 0);
         checkOutput($sformatf("bp_rel_valid_%0d", i), release_valid, 1);
         checkOutput($sformatf("bp_rel_wmask_%0d", i), release_wmask, 4'b1010);
         applyStimulus(1'b1, 2'd0, 2'd3, 2'd1);
      end
      checkOutput("bp_no_accept_stalled", stalled_wmask, 4'b0000);
      release_ready = 1'b1;
      #1;
      checkOutput("bp_ready_on_handshake", req_ready, 1);
      idleCycle();
      checkOutput("bp_after_rel_valid", release_valid, 0);
      checkOutput("bp_after_req_ready", req_ready, 1);

      // Size mismatch still counts against the latched size.
      applyStimulus(1'b1, 2'd0, 2'd2, 2'd1);
      applyStimulus(1'b1, 2'd2, 2'd2, 2'd2);
      checkOutput("size_err_valid", err_valid, 1);
      checkOutput("size_err_code", err_code, 2);
      checkOutput("size_rel_valid", release_valid, 1);
      checkOutput("size_rel_wmask", release_wmask, 4'b0101);
      idleCycle();

      // Interleave barriers 0 and 3, then reset mid-fill.
      applyStimulus(1'b1, 2'd0, 2'd0, 2'd1);
      applyStimulus(1'b1, 2'd2, 2'd3, 2'd1);
      checkOutput("interleave_stalled", stalled_wmask, 4'b0101);
      doReset();
      checkOutput("midrst_rel_valid", release_valid, 0);
      checkOutput("midrst_rel_wmask", release_wmask, 0);
      checkOutput("midrst_stalled", stalled_wmask, 0);
      checkOutput("midrst_err_valid", err_valid, 0);
      checkOutput("midrst_err_code", err_code, 0);
      applyStimulus(1'b1, 2'd1, 2'd0, 2'd1);
      checkOutput("fresh_rel_valid", release_valid, 0);
      checkOutput("fresh_stalled", stalled_wmask, 4'b0010);

`ifdef PERF_BARRIER_EN
      doReset();
      checkOutput("perf_rst_stall", perf_stall_cycles, 0);
      checkOutput("perf_rst_rel", perf_releases, 0);
      applyStimulus(1'b1, 2'd0, 2'd3, 2'd2);
      applyStimulus(1'b1, 2'd1, 2'd3, 2'd2);
      stallSnap = perf_stall_cycles;
      repeat (5) idleCycle();
      checkOutput("perf_stall_delta", perf_stall_cycles - stallSnap, 10);
      relSnap = perf_releases;
      applyStimulus(1'b1, 2'd2, 2'd3, 2'd2);
      idleCycle();
      checkOutput("perf_rel_delta", perf_releases - relSnap, 1);
`endif

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule

// File: doc/vx_barrier_unit.md
# VX_barrier_unit

Per-core warp barrier synchroniser. It sits between the GPU unit, which decodes `bar` instructions into barrier requests, and the warp scheduler, which parks and releases warps. It generalises the single barrier-request record into a parametrised table of `NUM_BARRIERS` independent barriers. Each barrier has an arrival counter, a waiting-warp mask, size checking, and a flow-controlled release output.

## Interface
Parameters:
- `NUM_WARPS`, 4: warps per core; power of two, ≥2.
- `NUM_BARRIERS`, 4: barrier slots; power of two, ≥1.
- `NW_BITS`, `$clog2(NUM_WARPS)`: warp-id width.
- `NB_BITS`, `$clog2(NUM_BARRIERS)` (min 1): barrier-id width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  barrier arrival request.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_wid`  in  NW_BITS  arriving warp id.
- `req_id`  in  NB_BITS  barrier id.
- `req_size_m1`  in  NW_BITS  participating warps minus one.
- `release_valid`  out  1  release record valid.
- `release_ready`  in  1  scheduler accepts release.
- `release_wmask`  out  NUM_WARPS  warps to unpark.
- `stalled_wmask`  out  NUM_WARPS  warps currently parked in any barrier.
- `err_valid`  out  1  one-cycle pulse: protocol error on last accepted request.
- `err_code`  out  2  1 = duplicate arrival, 2 = size mismatch; 0 when idle.

## Operation
- Each slot holds `wmask` (NUM_WARPS bits), `count` (NW_BITS bits, arrivals minus one once the slot is busy), `size_m1` (latched), and `busy`.
- Slot states:
  - IDLE (`busy`=0).
  - FILLING (`busy`=1).
- Accepted request on IDLE slot:
  - If `req_size_m1`==0, release `{req_wid}` immediately and the slot stays IDLE.
  - Otherwise go to FILLING, `wmask`=onehot(wid), `count`=0, latch `size_m1`.
- Accepted request on FILLING slot:
  - If `wmask[wid]` is already set, pulse `err_code`=1. The request is dropped and the state is unchanged.
  - Else, if `req_size_m1`≠latched `size_m1`, pulse `err_code`=2. The arrival still counts using the latched size.
  - If `count+1`==latched `size_m1`, load the release register with `wmask|onehot(wid)` and clear the slot to IDLE.
  - Otherwise set `wmask[wid]` and increment `count`.
- `stalled_wmask` = OR of `wmask` over all slots (registered state).
- Release register: one entry.
  - `release_valid` holds until `release_ready`.
  - `req_ready` = `!release_valid || release_ready`, so a completing request is never lost.
- A slot cleared by release accepts a new epoch on the next accepted request, including in the cycle immediately after.

## Timing
- Reset (`reset_n`=0 at edge) clears everything:
  - All slots go IDLE.
  - `release_valid`=0, `release_wmask`=0, `stalled_wmask`=0, `err_valid`=0, `err_code`=0, perf counters=0.
  - Parked warps are discarded; the scheduler is reset concurrently.
- `req_ready` is 0 during reset and 1 from the first cycle after reset.
- Accept at edge N:
  - `release_valid`/`release_wmask` are visible after N (1-cycle latency).
  - `stalled_wmask` is updated after N.
  - `err_valid` pulses for exactly the cycle after N.
- Release back-pressure: the register holds stable while `release_valid && !release_ready`. Same-cycle accept and reload is allowed when `release_ready`=1.
- One request per cycle. No combinational path from `req_*` to `release_*`. `req_ready` depends only on `release_valid`/`release_ready`.

## Configuration
- `PERF_BARRIER_EN` defined adds two outputs:
  - `perf_stall_cycles` (64 bits): adds popcount(`stalled_wmask`) every cycle.
  - `perf_releases` (32 bits): increments on each release handshake.
  - Both are wrap-around counters, cleared by reset.
- `PERF_BARRIER_EN` undefined: these ports and counters do not exist; functional behaviour is identical.

## Structure
- The `VX_gpu_types` package gains:
  - `gpu_barrier_req_t` {wid, id, size_m1}.
  - `gpu_barrier_rel_t` {wmask}.
  - Constants `BAR_ERR_NONE`/`BAR_ERR_DUP`/`BAR_ERR_SIZE`.
  - `GPU_BARRIER_REQ_BITS` macro.
- Sub-module `VX_barrier_entry`, one slot's state and next-state logic, generated `NUM_BARRIERS` times. The top level holds the id decode, release register, mask OR and perf counters.

## Test plan
- Size 4, warps 0,1,2,3 arrive on barrier 1 with `release_ready`=1 → `release_wmask`=4'b1111 one cycle after warp 3's accept; `stalled_wmask` goes 0001, 0011, 0111, then 0000.
- `req_size_m1`=0 from warp 2 → `release_wmask`=4'b0100 next cycle; `stalled_wmask` stays 0.
- Warp 1 arrives twice on barrier 0 (size 2) → `err_code`=1 pulse on the second arrival; `stalled_wmask`=0010 unchanged.
- Barrier 0 completes while `release_ready`=0 for 3 cycles → `req_ready`=0 and `release_wmask` stable for 3 cycles; handshake on the 4th cycle, then `req_ready`=1.
- Interleave barriers 0 and 3 (size 2 each), then apply `reset_n`=0 mid-fill → all outputs 0 after reset; a fresh single arrival does not release.
- With `PERF_BARRIER_EN`: 2 warps parked for 5 cycles → `perf_stall_cycles`=10; `perf_releases` increments by 1 per release handshake.
